pe_skew_feeder: RTL and testbench
=================================

// Module: pe_skew_feeder
// PURPOSE
//  Upstream operand feeder for one edge (row-A or column-B) of the PE systolic array.
//  Accepts one N-lane operand vector per beat (valid/ready) for a tile of len_i beats.
//  Drives lane i with data, we and clr delayed by i cycles (diagonal skew).
//  Emits a per-lane clr pulse before each tile so every PE restarts its accumulation.
//  Instantiate once for the A edge and once for the B edge; both edges start together.
// PARAMETERS
//  N_LANES   4    lanes = array rows (A edge) or columns (B edge)
//  LEN_W     8    width of tile length len_i (max tile 2^LEN_W-1 beats)
//  DATA_WIDTH is `DATA_WIDTH from def.v (16, Q8.8); no local override
// PORTS
//  clk_i      in   1                    clock
//  rst_ni     in   1                    async reset, active low
//  start_i    in   1                    start tile; sampled only in IDLE
//  len_i      in   LEN_W                beats in tile; captured with start_i
//  in_valid_i in   1                    input vector valid
//  in_ready_o out  1                    feeder accepts vector this cycle
//  in_data_i  in   N_LANES*DATA_WIDTH   lane i = bits [i*DW +: DW]
//  lane_o     out  N_LANES*DATA_WIDTH   skewed operands to PE srca_i/srcb_i
//  we_o       out  N_LANES              skewed write enable to PE we_i
//  clr_o      out  N_LANES              skewed clear to PE clr_i
//  busy_o     out  1                    tile in progress
//  done_o     out  1                    one-cycle pulse, tile fully drained
//  stall_cnt_o out 16                   only with PE_FEEDER_STALL_CNT_EN
// BEHAVIOUR
//  Reset (async, rst_ni=0): FSM=IDLE; all outputs 0; skew registers and counters cleared.
//  Reset mid-tile aborts the tile; no done_o.
//  FSM: IDLE -start_i-> CLR (1 cycle) -> STREAM -(len beats accepted)-> FLUSH -> IDLE.
//  If len_i==0: CLR -> FLUSH; no beats accepted; done_o still pulses.
//  start_i is ignored outside IDLE. len_i is latched at start.
//  in_ready_o = 1 only in STREAM while accepted < len.
//  Beat = in_valid_i & in_ready_o; input gaps become bubbles; no data is lost.
//  Lane 0 timing, with the beat accepted in cycle c:
//   - we_o[0]=1 in cycle c;
//   - lane_o[0] = that beat's lane-0 data in cycle c+1;
//   - we leads data by 1 cycle, matching the PE's registered-we/unregistered-operand
//     capture.
//  clr_o[0]=1 for the single CLR cycle. The first possible beat is the next cycle,
//   so PE clr_q wins over we_q.
//  Lane i: we_o[i], clr_o[i] and lane_o[i] equal lane-0's values delayed by exactly
//   i cycles. Each lane has its own shift-register chain (lane i has i stages plus the
//   1-cycle data stage).
//  lane_o[i] drives 0 in any cycle with no beat data in that slot (bubble or idle).
//  It never holds stale data.
//  Arithmetic: data passes through unmodified (no rounding or sign change);
//   only the beat counter is arithmetic, LEN_W bits, no wrap.
//  FLUSH: lasts N_LANES cycles after the last beat cycle L.
//   - lane_o[N-1] carries the last beat at L+N.
//   - done_o=1 in cycle L+N, then IDLE.
//   - len=0 case: FLUSH lasts N_LANES cycles after CLR.
//  busy_o = (state != IDLE), including the done_o cycle.
//  start_i in the done_o cycle is ignored; earliest new start is the next cycle.
//  in_valid_i while not ready: no effect; in_data_i need not be held.
// CONFIGURATION
//  `PE_FEEDER_STALL_CNT_EN defined:
//   - adds stall_cnt_o, cleared at start;
//   - +1 each STREAM cycle with in_ready_o=1 & in_valid_i=0;
//   - saturates at 16'hFFFF.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. len=3, N=4, valid every cycle, data lane i = beat*16+i
//     -> clr_o one-hot walks bits 0..3 on consecutive cycles;
//     -> we_o[i] high 3 cycles starting i cycles after lane 0;
//     -> lane_o[3] = 0x03,0x13,0x23; done_o exactly 4 cycles after last beat.
//  2. len=4, in_valid pattern 1,0,1,1,0,1
//     -> we_o[0] = 1,0,1,1,0,1; bubbles show lane_o=0 and propagate unchanged
//        down each lane's skew.
//     -> with macro: stall_cnt_o=2.
//  3. len=0 -> busy 1+N+... cycles, in_ready_o never high, clr_o pulses walk,
//     done_o pulses once.
//  4. start_i asserted during STREAM with different len_i -> ignored;
//     original len honoured, single done_o.
//  5. rst_ni low mid-STREAM (after 2 of 5 beats) -> all outputs 0 immediately,
//     IDLE, no done_o.
//     -> a new start then yields a full, correct tile.
//  6. Two feeders + 4x4 PE array, A=I, B = 1.0 (0x0100) matrix
//     -> each psum_o = 0x0100 after drain; back-to-back tile clears
//        the prior result.

Source files
------------

// File: rtl/pe_skew_feeder.sv
// ---------------------------------------------------------------------------
// pe_skew_feeder
//   Operand feeder for one edge (row-A or column-B) of the PE systolic array.
//   It accepts one N_LANES-wide operand vector per beat on a valid/ready
//   handshake for a tile of len_i beats. Lane i is driven with data, we and clr
//   delayed by i cycles, which produces the diagonal wavefront the array needs.
//   A one-cycle clr is sent down every lane before each tile so that each PE
//   restarts its accumulation. The A edge and the B edge each use one instance,
//   and both instances are started together.
//
//   Lane-0 timing for a beat accepted in cycle c:
//     we_o[0] = 1 in cycle c, and lane_o[0] = beat data in cycle c+1.
//   The PE registers we but not its operands, so we has to lead data by one
//   cycle.
//
// Optional feature (macro PE_FEEDER_STALL_CNT_EN):
//   Adds stall_cnt_o. It counts the STREAM cycles in which the feeder was ready
//   but no vector was offered. It is cleared at start and saturates at 16'hFFFF.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i, len_i     start a tile of len_i beats (sampled only in IDLE)
//   in_valid_i/in_ready_o/in_data_i   input vector handshake; lane i = [i*DW +: DW]
//   lane_o, we_o, clr_o               skewed operands / write enable / clear
//   busy_o             tile in progress (includes the done_o cycle)
//   done_o             one-cycle pulse when the last beat has left lane N-1
//   stall_cnt_o        stall counter (only with PE_FEEDER_STALL_CNT_EN)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

// The project-wide operand width normally comes from def.v; use Q8.8 if it is
// absent.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module pe_skew_feeder #(
  parameter int N_LANES = 4,
  parameter int LEN_W   = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [LEN_W-1:0]                 len_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [N_LANES*`DATA_WIDTH-1:0]   in_data_i,
  output logic [N_LANES*`DATA_WIDTH-1:0]   lane_o,
  output logic [N_LANES-1:0]               we_o,
  output logic [N_LANES-1:0]               clr_o,
  output logic                             busy_o,
  output logic                             done_o
`ifdef PE_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                      stall_cnt_o
`endif
);

  localparam int DW = `DATA_WIDTH;
  localparam int FW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_FLUSH
  } state_e;

  state_e           r_state;
  state_e           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [FW-1:0]    r_flush_cnt;
  logic             w_ready;
  logic             w_beat;
  logic             w_clr;
  logic             w_done;

  // The feeder is ready only while the tile still has beats left to accept.
  assign w_ready = (r_state == S_STREAM) && (r_cnt != r_len);
  assign w_beat  = in_valid_i & w_ready;

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the clock edge, whatever order the statements
  // are in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first. A path that leaves
  // a signal unassigned would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) w_next = S_CLR;
      end
      S_CLR: begin
        w_clr  = 1'b1;
        w_next = (r_len == '0) ? S_FLUSH : S_STREAM;
      end
      S_STREAM: begin
        if (w_beat && (r_cnt + LEN_W'(1) == r_len)) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        // The last beat leaves lane N-1 in the final FLUSH cycle.
        if (r_flush_cnt == FW'(N_LANES - 1)) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Tile bookkeeping: latched length, beat counter and flush counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && start_i) begin
        r_len <= len_i;
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
      r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + FW'(1) : '0;
    end
  end

`ifdef PE_FEEDER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (r_state == S_IDLE && start_i) begin
      r_stall_cnt <= '0;
    end else if (w_ready && !in_valid_i && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

  // Per-lane skew chains. Lane g holds a data stage that captures the beat
  // (or 0 for a bubble), followed by g delay stages. Its we/clr chain has g
  // stages, so all three signals keep lane 0's relative timing.
  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    logic [DW-1:0] r_data [g+1];

    // NOTE: the skew chains are reset as well, even though they are only
    // storage. Without the reset they would present stale operands to the
    // array after a reset, and a lane must drive 0 whenever no beat occupies
    // its slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k <= g; k++) r_data[k] <= '0;
      end else begin
        r_data[0] <= w_beat ? in_data_i[g*DW +: DW] : '0;
        for (int k = 1; k <= g; k++) r_data[k] <= r_data[k-1];
      end
    end

    assign lane_o[g*DW +: DW] = r_data[g];

    if (g == 0) begin : g_head
      assign we_o[0]  = w_beat;
      assign clr_o[0] = w_clr;
    end else begin : g_tail
      logic [g-1:0] r_we;
      logic [g-1:0] r_clr;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_we  <= '0;
          r_clr <= '0;
        end else begin
          r_we[0]  <= w_beat;
          r_clr[0] <= w_clr;
          for (int k = 1; k < g; k++) begin
            r_we[k]  <= r_we[k-1];
            r_clr[k] <= r_clr[k-1];
          end
        end
      end

      assign we_o[g]  = r_we[g-1];
      assign clr_o[g] = r_clr[g-1];
    end
  end

  assign in_ready_o = w_ready;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = w_done;

endmodule

// File: tb/tb_pe_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_pe_skew_feeder
//   Directed bench for pe_skew_feeder with N_LANES=4, LEN_W=8 and DW=16.
//   Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
//   falling edge. Each scenario states the lane-0 behaviour for every cycle as
//   hand-written bit vectors (bit t = cycle t after the scenario starts):
//   accepted beats, clr pulses, ready, busy and done. The other lanes are the
//   same vectors delayed by the lane index. Beat b's data on lane i is
//   base + b*16 + i, and it appears on lane i one cycle after the beat plus i
//   cycles of skew.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pe_skew_feeder;

  localparam int N    = 4;
  localparam int LW   = 8;
  localparam int DW   = 16;
  localparam int MAXC = 24;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic [LW-1:0]     len_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [N*DW-1:0]   in_data_i;
  logic [N*DW-1:0]   lane_o;
  logic [N-1:0]      we_o;
  logic [N-1:0]      clr_o;
  logic              busy_o;
  logic              done_o;
`ifdef PE_FEEDER_STALL_CNT_EN
  logic [15:0]       stall_cnt_o;
`endif

  pe_skew_feeder #(.N_LANES(N), .LEN_W(LW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .len_i      (len_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .lane_o     (lane_o),
    .we_o       (we_o),
    .clr_o      (clr_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef PE_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Per-cycle trace of {ready, busy, done, clr[3:0], we[3:0]} and lane_o.
  logic [10:0]     tr_ctl  [MAXC];
  logic [N*DW-1:0] tr_lane [MAXC];
  logic [10:0]     ex_ctl  [MAXC];
  logic [N*DW-1:0] ex_lane [MAXC];

  // Runs n cycles starting at rising edge + 1 ns. Start is asserted in the
  // cycles set in spat, and valid in the cycles set in vpat. len_i is len0 in
  // cycle 0 and len1 afterwards. A valid vector k carries base + k*16 + lane;
  // an invalid cycle carries junk that must be ignored.
  task automatic run_trace(input int n, input logic [MAXC-1:0] spat,
                           input logic [LW-1:0] len0, input logic [LW-1:0] len1,
                           input logic [MAXC-1:0] vpat, input logic [15:0] base);
    int k;
    k = 0;
    for (int t = 0; t < n; t++) begin
      start_i    = spat[t];
      len_i      = (t == 0) ? len0 : len1;
      in_valid_i = vpat[t];
      for (int i = 0; i < N; i++)
        in_data_i[i*DW +: DW] = vpat[t] ? base + 16'(k*16 + i) : 16'hBAD0 + 16'(i);
      if (vpat[t]) k++;
      @(negedge clk_i);
      tr_ctl[t]  = {in_ready_o, busy_o, done_o, clr_o, we_o};
      tr_lane[t] = lane_o;
      @(posedge clk_i);
      #1;
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;
  endtask

  // Expected trace built from the lane-0 description of the scenario.
  function automatic void build_expected(input int n, input logic [MAXC-1:0] we0,
                                         input logic [MAXC-1:0] clr0,
                                         input logic [MAXC-1:0] rdy,
                                         input logic [MAXC-1:0] bsy,
                                         input logic [MAXC-1:0] dne,
                                         input logic [15:0] base);
    for (int t = 0; t < n; t++) begin
      logic [N-1:0]    we;
      logic [N-1:0]    clr;
      logic [N*DW-1:0] ln;
      for (int i = 0; i < N; i++) begin
        int c;
        int b;
        we[i]  = (t >= i) ? we0[t-i]  : 1'b0;
        clr[i] = (t >= i) ? clr0[t-i] : 1'b0;
        c = t - 1 - i;
        ln[i*DW +: DW] = '0;
        if (c >= 0 && we0[c]) begin
          b = 0;
          for (int j = 0; j < c; j++) if (we0[j]) b++;
          ln[i*DW +: DW] = base + 16'(b*16 + i);
        end
      end
      ex_ctl[t]  = {rdy[t], bsy[t], dne[t], clr, we};
      ex_lane[t] = ln;
    end
  endfunction

  task automatic test_reset();
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    len_i      = '0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({in_ready_o, busy_o, done_o, clr_o, we_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_ctl got %b expected 0", {in_ready_o, busy_o, done_o, clr_o, we_o});
    end
    checks++;
    if (lane_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_lane got %h expected 0", lane_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if ({in_ready_o, busy_o, done_o, clr_o, we_o, lane_o} !== 75'd0) begin
      errors++;
      $display("FAIL post_reset_idle got %h expected 0", {in_ready_o, busy_o, done_o, clr_o, we_o, lane_o});
    end
  endtask

  // len=3, valid every cycle: CLR at c1, beats c2..c4, done at c8.
  task automatic test_basic_tile();
    run_trace(10, 24'h1, 8'd3, 8'd3, 24'h1C, 16'h0000);
    build_expected(10, 24'h1C, 24'h2, 24'h1C, 24'h1FE, 24'h100, 16'h0000);
    for (int t = 0; t < 10; t++) begin
      checks++;
      if (tr_ctl[t] !== ex_ctl[t]) begin
        errors++;
        $display("FAIL basic_ctl cycle %0d got rdy/busy/done/clr/we %b expected %b", t, tr_ctl[t], ex_ctl[t]);
      end
      checks++;
      if (tr_lane[t] !== ex_lane[t]) begin
        errors++;
        $display("FAIL basic_lane cycle %0d got %h expected %h", t, tr_lane[t], ex_lane[t]);
      end
    end
`ifdef PE_FEEDER_STALL_CNT_EN
    checks++;
    if (stall_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL basic_stall got %0d expected 0", stall_cnt_o);
    end
`endif
  endtask

  // len=4, valid 1,0,1,1,0,1 from c2: beats c2,c4,c5,c7, done at c11.
  task automatic test_bubbles();
    run_trace(13, 24'h1, 8'd4, 8'd4, 24'hB4, 16'h0000);
    build_expected(13, 24'hB4, 24'h2, 24'hFC, 24'hFFE, 24'h800, 16'h0000);
    for (int t = 0; t < 13; t++) begin
      checks++;
      if (tr_ctl[t] !== ex_ctl[t]) begin
        errors++;
        $display("FAIL bubble_ctl cycle %0d got rdy/busy/done/clr/we %b expected %b", t, tr_ctl[t], ex_ctl[t]);
      end
      checks++;
      if (tr_lane[t] !== ex_lane[t]) begin
        errors++;
        $display("FAIL bubble_lane cycle %0d got %h expected %h", t, tr_lane[t], ex_lane[t]);
      end
    end
`ifdef PE_FEEDER_STALL_CNT_EN
    checks++;
    if (stall_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL bubble_stall got %0d expected 2", stall_cnt_o);
    end
`endif
  endtask

  // len=0 with valid held high: CLR at c1, FLUSH c2..c5, done at c5, no beats.
  task automatic test_zero_len();
    run_trace(8, 24'h1, 8'd0, 8'd0, 24'hFFFFFF, 16'h0000);
    build_expected(8, 24'h0, 24'h2, 24'h0, 24'h3E, 24'h20, 16'h0000);
    for (int t = 0; t < 8; t++) begin
      checks++;
      if (tr_ctl[t] !== ex_ctl[t]) begin
        errors++;
        $display("FAIL zero_len_ctl cycle %0d got rdy/busy/done/clr/we %b expected %b", t, tr_ctl[t], ex_ctl[t]);
      end
      checks++;
      if (tr_lane[t] !== ex_lane[t]) begin
        errors++;
        $display("FAIL zero_len_lane cycle %0d got %h expected %h", t, tr_lane[t], ex_lane[t]);
      end
    end
  endtask

  // len=3, with start re-asserted in STREAM (c3, len 7) and in the done cycle
  // (c8). Valid stays high after the tile, so the extra vectors must be refused.
  task automatic test_start_ignored();
    run_trace(12, 24'h109, 8'd3, 8'd7, 24'h3FFC, 16'h0000);
    build_expected(12, 24'h1C, 24'h2, 24'h1C, 24'h1FE, 24'h100, 16'h0000);
    for (int t = 0; t < 12; t++) begin
      checks++;
      if (tr_ctl[t] !== ex_ctl[t]) begin
        errors++;
        $display("FAIL restart_ctl cycle %0d got rdy/busy/done/clr/we %b expected %b", t, tr_ctl[t], ex_ctl[t]);
      end
      checks++;
      if (tr_lane[t] !== ex_lane[t]) begin
        errors++;
        $display("FAIL restart_lane cycle %0d got %h expected %h", t, tr_lane[t], ex_lane[t]);
      end
    end
  endtask

  // len=5, reset after 2 beats; then idle with no done, then a full new tile.
  task automatic test_reset_mid_tile();
    run_trace(4, 24'h1, 8'd5, 8'd5, 24'hFFFFFC, 16'h0000);
    build_expected(4, 24'hC, 24'h2, 24'hC, 24'hE, 24'h0, 16'h0000);
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (tr_ctl[t] !== ex_ctl[t]) begin
        errors++;
        $display("FAIL abort_pre_ctl cycle %0d got %b expected %b", t, tr_ctl[t], ex_ctl[t]);
      end
    end
    in_valid_i = 1'b1;
    rst_ni     = 1'b0;
    #1;
    checks++;
    if ({in_ready_o, busy_o, done_o, clr_o, we_o} !== 11'd0) begin
      errors++;
      $display("FAIL abort_ctl got %b expected 0", {in_ready_o, busy_o, done_o, clr_o, we_o});
    end
    checks++;
    if (lane_o !== 64'd0) begin
      errors++;
      $display("FAIL abort_lane got %h expected 0", lane_o);
    end
    in_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    run_trace(6, 24'h0, 8'd0, 8'd0, 24'h0, 16'h0000);
    build_expected(6, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 16'h0000);
    for (int t = 0; t < 6; t++) begin
      checks++;
      if (tr_ctl[t] !== ex_ctl[t] || tr_lane[t] !== ex_lane[t]) begin
        errors++;
        $display("FAIL abort_idle cycle %0d got %b/%h expected idle zeros", t, tr_ctl[t], tr_lane[t]);
      end
    end
    run_trace(10, 24'h1, 8'd3, 8'd3, 24'h1C, 16'h0100);
    build_expected(10, 24'h1C, 24'h2, 24'h1C, 24'h1FE, 24'h100, 16'h0100);
    for (int t = 0; t < 10; t++) begin
      checks++;
      if (tr_ctl[t] !== ex_ctl[t]) begin
        errors++;
        $display("FAIL after_abort_ctl cycle %0d got %b expected %b", t, tr_ctl[t], ex_ctl[t]);
      end
      checks++;
      if (tr_lane[t] !== ex_lane[t]) begin
        errors++;
        $display("FAIL after_abort_lane cycle %0d got %h expected %h", t, tr_lane[t], ex_lane[t]);
      end
    end
  endtask

  // Two len=2 tiles, the second started in the first IDLE cycle after done
  // (c8). Both tiles must see a CLR wavefront.
  task automatic test_back_to_back();
    run_trace(17, 24'h101, 8'd2, 8'd2, 24'hC0C, 16'h0200);
    build_expected(17, 24'hC0C, 24'h202, 24'hC0C, 24'hFEFE, 24'h8080, 16'h0200);
    for (int t = 0; t < 17; t++) begin
      checks++;
      if (tr_ctl[t] !== ex_ctl[t]) begin
        errors++;
        $display("FAIL b2b_ctl cycle %0d got rdy/busy/done/clr/we %b expected %b", t, tr_ctl[t], ex_ctl[t]);
      end
      checks++;
      if (tr_lane[t] !== ex_lane[t]) begin
        errors++;
        $display("FAIL b2b_lane cycle %0d got %h expected %h", t, tr_lane[t], ex_lane[t]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_tile();
    test_bubbles();
    test_zero_len();
    test_start_ignored();
    test_reset_mid_tile();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
